bias_act: RTL and testbench

Parametrised bias-add and activation layer engine; successor to the fixed-size ReLU stage in the CNN accelerator datapath. It reads layer parameters and per-channel biases from DRAM, then streams a W×H×D feature map. Each pixel gets a saturating bias add and a selectable activation (bypass, ReLU, leaky ReLU), and the result is written back to DRAM. It sits between the convolution engine and the pooling stage and shares the single-port DRAM arbiter with them.

---
 rtl/bias_act_pkg.sv | 30 +++
 rtl/bias_act_act.sv | 36 +++
 rtl/bias_act.sv | 185 ++++++++++++++++++
 tb/tb_bias_act.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_act_pkg.sv
// Shared types and default constants for the bias_act layer engine.
// Imported by the top level and by act_unit.
package bias_act_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_LD_PARAM = 5'b00010,
    S_LD_BIAS  = 5'b00100,
    S_EVAL     = 5'b01000,
    S_DONE     = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_RELU    = 2'd1,
    MODE_LEAKY   = 2'd2,
    MODE_RELU_HI = 2'd3
  } mode_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_KNL_MAXNUM = 64;
  localparam int DEF_DIM_WIDTH  = 6;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_PARAM_BASE = 0;
  localparam int DEF_BIAS_BASE  = 61504;
  localparam int DEF_FIN_BASE   = 131072;
  localparam int DEF_FOUT_BASE  = 131072;

endpackage

// File: rtl/bias_act_act.sv
// act_unit: combinational saturating bias add followed by the selected activation.
// The add is one bit wider than the data so overflow shows up as a sign mismatch.
module act_unit
  import bias_act_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic signed [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  mode_t                        mode,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH:0]   sum;
  logic signed [DATA_WIDTH-1:0] sat;

  always_comb begin
    sum = {pixel[DATA_WIDTH-1], pixel} + {bias[DATA_WIDTH-1], bias};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
    result = sat;
    case (mode)
      MODE_BYPASS: result = sat;
      MODE_LEAKY:  if (sat[DATA_WIDTH-1]) result = sat >>> LEAK_SHIFT;
      default:     if (sat[DATA_WIDTH-1]) result = '0;
    endcase
  end

endmodule

// File: rtl/bias_act.sv
// bias_act: loads layer parameters and per-channel biases from DRAM, then streams
// the feature map through act_unit and writes each result back one cycle later.
module bias_act
  import bias_act_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int KNL_MAXNUM = DEF_KNL_MAXNUM,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int PARAM_BASE = DEF_PARAM_BASE,
  parameter int BIAS_BASE  = DEF_BIAS_BASE,
  parameter int FIN_BASE   = DEF_FIN_BASE,
  parameter int FOUT_BASE  = DEF_FOUT_BASE
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done,
  output logic                  err
);

  localparam int BIAS_IDX_W = (KNL_MAXNUM > 1) ? $clog2(KNL_MAXNUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] PARAM_ADDR = ADDR_WIDTH'(PARAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] BIAS_ADDR  = ADDR_WIDTH'(BIAS_BASE);
  localparam logic [ADDR_WIDTH-1:0] FIN_ADDR   = ADDR_WIDTH'(FIN_BASE);
  localparam logic [ADDR_WIDTH-1:0] FOUT_ADDR  = ADDR_WIDTH'(FOUT_BASE);
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE    = DIM_WIDTH'(1);

  state_t                  state, state_nxt;
  logic [2:0]              param_cnt;
  logic                    param_pend;
  logic [1:0]              param_idx;
  logic [DIM_WIDTH-1:0]    w_dim, h_dim, d_dim;
  logic                    d_over;
  mode_t                   mode_q;
  logic [DIM_WIDTH-1:0]    bias_cnt, w_cnt, h_cnt, d_cnt;
  logic                    bias_pend;
  logic [BIAS_IDX_W-1:0]   bias_idx;
  logic [ADDR_WIDTH-1:0]   pix_cnt;
  logic                    wr_pend;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [BIAS_IDX_W-1:0]   wr_d;
  logic [DATA_WIDTH-1:0]   bias_mem [KNL_MAXNUM];
  logic [DATA_WIDTH-1:0]   act_result;
  logic accept, capture, param_err, last_bias, w_last, h_last, d_last;

  assign accept    = dram_en_rd & dram_valid;
  assign capture   = param_cnt[2];
  assign param_err = (w_dim == '0) | (h_dim == '0) | (d_dim == '0) | d_over;
  assign last_bias = (bias_cnt == d_dim - DIM_ONE);
  assign w_last    = (w_cnt == w_dim - DIM_ONE);
  assign h_last    = (h_cnt == h_dim - DIM_ONE);
  assign d_last    = (d_cnt == d_dim - DIM_ONE);

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_LD_PARAM;
      S_LD_PARAM: if (capture) state_nxt = param_err ? S_DONE : S_LD_BIAS;
      S_LD_BIAS:  if (accept && last_bias) state_nxt = S_EVAL;
      S_EVAL:     if (accept && w_last && h_last && d_last) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dram_en_rd = 1'b0;
    addr_in    = '0;
    done       = 1'b0;
    case (state)
      S_LD_PARAM: if (!capture) begin
        dram_en_rd = 1'b1;
        addr_in    = PARAM_ADDR + ADDR_WIDTH'(param_cnt);
      end
      S_LD_BIAS: begin
        dram_en_rd = 1'b1;
        addr_in    = BIAS_ADDR + ADDR_WIDTH'(bias_cnt);
      end
      S_EVAL: begin
        dram_en_rd = 1'b1;
        addr_in    = FIN_ADDR + pix_cnt;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters only move on an accepted read; read data is consumed the cycle after.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      param_cnt <= '0;  param_pend <= 1'b0; param_idx <= '0;
      w_dim     <= '0;  h_dim      <= '0;   d_dim     <= '0;
      d_over    <= 1'b0; mode_q    <= MODE_BYPASS;
      bias_cnt  <= '0;  bias_pend  <= 1'b0; bias_idx  <= '0;
      w_cnt     <= '0;  h_cnt      <= '0;   d_cnt     <= '0;
      pix_cnt   <= '0;  wr_pend    <= 1'b0; wr_addr   <= '0; wr_d <= '0;
    end else begin
      param_pend <= 1'b0;
      bias_pend  <= 1'b0;
      wr_pend    <= 1'b0;
      if (state == S_IDLE && enable) begin
        param_cnt <= '0; bias_cnt <= '0;
        w_cnt     <= '0; h_cnt    <= '0; d_cnt <= '0; pix_cnt <= '0;
      end
      if (accept && state == S_LD_PARAM) begin
        param_pend <= 1'b1;
        param_idx  <= param_cnt[1:0];
        param_cnt  <= param_cnt + 3'd1;
      end
      if (accept && state == S_LD_BIAS) begin
        bias_pend <= 1'b1;
        bias_idx  <= BIAS_IDX_W'(bias_cnt);
        bias_cnt  <= bias_cnt + DIM_ONE;
      end
      if (accept && state == S_EVAL) begin
        wr_pend <= 1'b1;
        wr_addr <= FOUT_ADDR + pix_cnt;
        wr_d    <= BIAS_IDX_W'(d_cnt);
        pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
        if (w_last) begin
          w_cnt <= '0;
          if (h_last) begin
            h_cnt <= '0;
            d_cnt <= d_cnt + DIM_ONE;
          end else begin
            h_cnt <= h_cnt + DIM_ONE;
          end
        end else begin
          w_cnt <= w_cnt + DIM_ONE;
        end
      end
      // The depth range check uses the whole word so that e.g. 65 cannot alias to 1.
      if (param_pend) begin
        case (param_idx)
          2'd0: w_dim <= data_in[DIM_WIDTH-1:0];
          2'd1: h_dim <= data_in[DIM_WIDTH-1:0];
          2'd2: begin
            d_dim  <= data_in[DIM_WIDTH-1:0];
            d_over <= (data_in > DATA_WIDTH'(KNL_MAXNUM));
          end
          default: mode_q <= mode_t'(data_in[1:0]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)                               err <= 1'b0;
    else if (state == S_IDLE && enable)       err <= 1'b0;
    else if (state == S_LD_PARAM && capture && param_err) err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (bias_pend) bias_mem[bias_idx] <= data_in;
  end

  act_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_act (
    .pixel  (data_in),
    .bias   (bias_mem[wr_d]),
    .mode   (mode_q),
    .result (act_result)
  );

  assign dram_en_wr = wr_pend;
  assign data_out   = wr_pend ? act_result : '0;
  assign addr_out   = wr_pend ? wr_addr : '0;

endmodule

// File: tb/tb_bias_act.sv
// Self-checking bench for bias_act: a DRAM model feeds the DUT and a monitor collects
// writes, which each scenario task compares against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bias_act;

  localparam int DW     = 32;
  localparam int AW     = 18;
  localparam int LEAK   = 3;
  localparam int BIAS_B = 61504;
  localparam int FIN_B  = 131072;
  localparam int FOUT_B = 131072;
  localparam int AMASK  = (1 << AW) - 1;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483647 - 64'sd1;

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          enable = 1'b0;
  logic          dram_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_in, addr_out;
  logic          dram_en_rd, dram_en_wr, done, err;

  int passed = 0;
  int total = 0;
  int valid_mode = 0;
  int stall_wr = 0;
  int idle_dirty = 0;
  bit rd_pend = 1'b0;
  int rd_addr = 0;
  logic [31:0] mem [int];
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  bias_act dut (
    .clk        (clk),
    .srstn      (srstn),
    .enable     (enable),
    .dram_valid (dram_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .dram_en_rd (dram_en_rd),
    .dram_en_wr (dram_en_wr),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // DRAM model: data for a read accepted in cycle t is presented in cycle t+1.
  always @(posedge clk) begin
    #1;
    data_in = (rd_pend && mem.exists(rd_addr)) ? mem[rd_addr] : 32'hDEAD_BEEF;
    case (valid_mode)
      0:       dram_valid = 1'b1;
      1:       dram_valid = ~dram_valid;
      default: dram_valid = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Mid-cycle monitor: collects writes and tracks protocol violations.
  always @(negedge clk) begin
    if (dram_en_wr) begin
      obs_addr.push_back(addr_out);
      obs_data.push_back(data_out);
      if (!rd_pend) stall_wr++;
    end else if (data_out !== '0) begin
      idle_dirty++;
    end
    if (!dram_en_rd && addr_in !== '0) idle_dirty++;
    rd_pend = dram_en_rd && dram_valid;
    rd_addr = int'(addr_in);
  end

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 200)) - 32'd100;
  endfunction

  task automatic load_job(input int w, input int h, input logic [31:0] dword, input int mode);
    int d;
    d = (dword <= 32'd63) ? int'(dword) : 0;
    mem.delete();
    mem[0] = 32'(w);
    mem[1] = 32'(h);
    mem[2] = dword;
    mem[3] = ($urandom & 32'hFFFF_FFFC) | 32'(mode);
    for (int c = 0; c < 64; c++) mem[BIAS_B + c] = rand_word();
    for (int i = 0; i < w * h * d; i++) mem[(FIN_B + i) & AMASK] = rand_word();
  endtask

  // Reference model: walks the map in w-innermost order with plain integer arithmetic.
  task automatic build_expected(input int w, input int h, input int d, input int mode);
    exp_addr.delete();
    exp_data.delete();
    for (int dd = 0; dd < d; dd++)
      for (int hh = 0; hh < h; hh++)
        for (int ww = 0; ww < w; ww++) begin
          int off, px, bs;
          longint s, r;
          off = (dd * h + hh) * w + ww;
          px  = mem[(FIN_B + off) & AMASK];
          bs  = mem[BIAS_B + dd];
          s   = longint'(px) + longint'(bs);
          if (s > MAXV) s = MAXV;
          if (s < MINV) s = MINV;
          case (mode)
            0:       r = s;
            2:       r = (s < 0) ? -((-s + (1 << LEAK) - 1) / (1 << LEAK)) : s;
            default: r = (s < 0) ? 0 : s;
          endcase
          exp_addr.push_back(AW'((FOUT_B + off) & AMASK));
          exp_data.push_back(DW'(r));
        end
  endtask

  task automatic pulse_enable();
    obs_addr.delete();
    obs_data.delete();
    stall_wr   = 0;
    idle_dirty = 0;
    @(posedge clk); #2 enable = 1'b1;
    @(posedge clk); #2 enable = 1'b0;
  endtask

  // Cycle 1 is the cycle after enable; returns the cycle in which done was seen.
  task automatic go_job(output int n, output bit to);
    pulse_enable();
    n  = 1;
    to = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 5000) begin to = 1'b1; break; end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    valid_mode = 0;
    srstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (data_out !== '0)    $display("[TB] FAIL reset_data_out got %h want 0", data_out); else passed++;
    total++; if (addr_in !== '0)     $display("[TB] FAIL reset_addr_in got %h want 0", addr_in); else passed++;
    total++; if (addr_out !== '0)    $display("[TB] FAIL reset_addr_out got %h want 0", addr_out); else passed++;
    total++; if (dram_en_rd !== 1'b0) $display("[TB] FAIL reset_en_rd got %b want 0", dram_en_rd); else passed++;
    total++; if (dram_en_wr !== 1'b0) $display("[TB] FAIL reset_en_wr got %b want 0", dram_en_wr); else passed++;
    total++; if (done !== 1'b0)      $display("[TB] FAIL reset_done got %b want 0", done); else passed++;
    total++; if (err !== 1'b0)       $display("[TB] FAIL reset_err got %b want 0", err); else passed++;
    @(posedge clk); #2 srstn = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dram_en_rd !== 1'b0) $display("[TB] FAIL idle_en_rd got %b want 0", dram_en_rd); else passed++;
  endtask

  task automatic test_basic();
    int n;
    bit to;
    valid_mode = 0;
    load_job(2, 2, 32'd2, 1);
    mem[BIAS_B]     = 32'd5;
    mem[BIAS_B + 1] = 32'hFFFF_FFFB;
    for (int i = 0; i < 8; i++) mem[FIN_B + i] = (i % 2 == 0) ? 32'd10 : 32'hFFFF_FFF6;
    build_expected(2, 2, 2, 1);
    go_job(n, to);
    total++; if (to)      $display("[TB] FAIL basic_timeout got no done want done"); else passed++;
    total++; if (n != 16) $display("[TB] FAIL basic_done_cycle got %0d want 16", n); else passed++;
    total++; if (obs_addr.size() != 8) $display("[TB] FAIL basic_nwrites got %0d want 8", obs_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= obs_addr.size())
        $display("[TB] FAIL basic_write[%0d] got none want %h:%h", i, exp_addr[i], exp_data[i]);
      else if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL basic_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++; if (obs_data.size() > 1 && obs_data[0] !== 32'd15) $display("[TB] FAIL basic_ch0_pos got %0d want 15", obs_data[0]); else passed++;
    total++; if (obs_data.size() > 4 && obs_data[4] !== 32'd5)  $display("[TB] FAIL basic_ch1_pos got %0d want 5", obs_data[4]); else passed++;
    total++; if (idle_dirty != 0) $display("[TB] FAIL basic_idle_outputs got %0d want 0", idle_dirty); else passed++;
    total++; if (err !== 1'b0)    $display("[TB] FAIL basic_err got %b want 0", err); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0)   $display("[TB] FAIL basic_done_width got %b want 0", done); else passed++;
  endtask

  task automatic test_edge_values();
    int n;
    bit to;
    int          modes [4] = '{2, 0, 0, 0};
    logic [31:0] biases[4] = '{32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] pixels[4] = '{32'hFFFF_FFEF, 32'hFFFF_FFEF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] wants [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFEF, 32'h7FFF_FFFF, 32'h8000_0000};
    valid_mode = 0;
    for (int k = 0; k < 4; k++) begin
      load_job(1, 1, 32'd1, modes[k]);
      mem[BIAS_B] = biases[k];
      mem[FIN_B]  = pixels[k];
      go_job(n, to);
      total++;
      if (to || obs_data.size() != 1)
        $display("[TB] FAIL edge_%0d got %0d writes want 1", k, obs_data.size());
      else if (obs_data[0] !== wants[k])
        $display("[TB] FAIL edge_%0d got %h want %h", k, obs_data[0], wants[k]);
      else passed++;
    end
  endtask

  task automatic test_param_err();
    int n;
    bit to;
    int          ws[3] = '{2, 2, 0};
    logic [31:0] ds[3] = '{32'd0, 32'd65, 32'd2};
    valid_mode = 0;
    for (int k = 0; k < 3; k++) begin
      load_job(ws[k], 2, ds[k], 1);
      go_job(n, to);
      total++; if (to || n != 6) $display("[TB] FAIL err_%0d_done_cycle got %0d want 6", k, n); else passed++;
      total++; if (obs_addr.size() != 0) $display("[TB] FAIL err_%0d_nwrites got %0d want 0", k, obs_addr.size()); else passed++;
      total++; if (err !== 1'b1) $display("[TB] FAIL err_%0d_flag got %b want 1", k, err); else passed++;
    end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) $display("[TB] FAIL err_held got %b want 1", err); else passed++;
  endtask

  task automatic test_valid_toggle();
    int n, mode;
    bit to;
    valid_mode = 1;
    mode = $urandom_range(0, 3);
    load_job(3, 2, 32'd2, mode);
    build_expected(3, 2, 2, mode);
    go_job(n, to);
    total++; if (to) $display("[TB] FAIL toggle_timeout got no done want done"); else passed++;
    total++; if (obs_addr.size() != exp_addr.size()) $display("[TB] FAIL toggle_nwrites got %0d want %0d", obs_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= obs_addr.size())
        $display("[TB] FAIL toggle_write[%0d] got none want %h:%h", i, exp_addr[i], exp_data[i]);
      else if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL toggle_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++; if (stall_wr != 0) $display("[TB] FAIL toggle_stall_write got %0d want 0", stall_wr); else passed++;
    total++; if (err !== 1'b0)  $display("[TB] FAIL toggle_err_cleared got %b want 0", err); else passed++;
  endtask

  task automatic test_random_jobs();
    int n, w, h, d, mode, bad;
    bit to;
    for (int j = 0; j < 5; j++) begin
      w = $urandom_range(1, 4);
      h = $urandom_range(1, 4);
      d = $urandom_range(1, 4);
      mode = $urandom_range(0, 3);
      valid_mode = (j % 2 == 0) ? 0 : 2;
      load_job(w, h, 32'(d), mode);
      build_expected(w, h, d, mode);
      go_job(n, to);
      bad = 0;
      for (int i = 0; i < exp_addr.size(); i++)
        if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          if (bad == 0 && i < obs_addr.size())
            $display("[TB] FAIL rand_%0d_write[%0d] got %h:%h want %h:%h", j, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
          bad++;
        end
      total++; if (to || obs_addr.size() != exp_addr.size()) $display("[TB] FAIL rand_%0d_nwrites got %0d want %0d", j, obs_addr.size(), exp_addr.size()); else passed++;
      total++; if (bad != 0) $display("[TB] FAIL rand_%0d_data got %0d bad writes want 0", j, bad); else passed++;
      total++; if (stall_wr != 0 || idle_dirty != 0) $display("[TB] FAIL rand_%0d_protocol got %0d/%0d want 0/0", j, stall_wr, idle_dirty); else passed++;
      if (valid_mode == 0) begin
        total++; if (n != 5 + d + w * h * d + 1) $display("[TB] FAIL rand_%0d_latency got %0d want %0d", j, n, 5 + d + w * h * d + 1); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_eval();
    int k, nwr, n, mode;
    bit to;
    valid_mode = 0;
    load_job(4, 4, 32'd2, 2);
    pulse_enable();
    k = 0;
    while (obs_addr.size() < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++; if (k >= 200) $display("[TB] FAIL rst_reach_eval got %0d writes want 5", obs_addr.size()); else passed++;
    #2 srstn = 1'b0;
    #1;
    total++; if (dram_en_wr !== 1'b0 || data_out !== '0 || addr_out !== '0)
      $display("[TB] FAIL rst_async_wr got %b:%h:%h want 0:0:0", dram_en_wr, addr_out, data_out); else passed++;
    total++; if (dram_en_rd !== 1'b0 || addr_in !== '0 || done !== 1'b0)
      $display("[TB] FAIL rst_async_rd got %b:%h:%b want 0:0:0", dram_en_rd, addr_in, done); else passed++;
    nwr = obs_addr.size();
    stall_wr = 0;
    repeat (3) @(posedge clk);
    #2 srstn = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (obs_addr.size() != nwr || stall_wr != 0) $display("[TB] FAIL rst_no_write got %0d want %0d", obs_addr.size(), nwr); else passed++;
    mode = $urandom_range(0, 3);
    load_job(2, 3, 32'd2, mode);
    build_expected(2, 3, 2, mode);
    go_job(n, to);
    total++; if (to || n != 5 + 2 + 12 + 1) $display("[TB] FAIL rst_rerun_cycle got %0d want 20", n); else passed++;
    total++; if (obs_addr.size() != exp_addr.size()) $display("[TB] FAIL rst_rerun_nwrites got %0d want %0d", obs_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size(); i++) begin
      total++;
      if (i >= obs_addr.size())
        $display("[TB] FAIL rst_rerun_write[%0d] got none want %h:%h", i, exp_addr[i], exp_data[i]);
      else if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("[TB] FAIL rst_rerun_write[%0d] got %h:%h want %h:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_values();
    test_param_err();
    test_valid_toggle();
    test_random_jobs();
    test_reset_mid_eval();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
